// File: rtl/typedefs.sv
// Shared types for the retire-to-memory store path.
//   memReqStruct  : one retired store request {valid, addr, wr_data}
//   sbEntryStruct : one buffered store {addr, wr_data}
//   SB_DEPTH      : default store buffer depth
package typedefs;

   localparam int SB_DEPTH  = 8;
   localparam int SB_ADDR_W = 32;
   localparam int SB_DATA_W = 32;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] wr_data;
   } memReqStruct;

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] wr_data;
   } sbEntryStruct;

endpackage

// File: rtl/store_commit_buffer_fwd_match.sv
// sb_fwd_match: youngest-first address match over the occupied store
// buffer entries, used for store-to-load forwarding.
// Ports:
//   head_i     : index of the oldest entry
//   count_i    : number of occupied entries
//   entries_i  : entry array
//   ld_valid_i : lookup enable
//   ld_addr_i  : load address (word granular compare)
//   hit_o      : some occupied entry matches
//   idx_o      : slot of the youngest matching entry
module sb_fwd_match
   import typedefs::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int PW     = $clog2(DEPTH),
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic [PW-1:0]     head_i,
   input  logic [CW-1:0]     count_i,
   input  sbEntryStruct      entries_i [DEPTH],
   input  logic              ld_valid_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   output logic              hit_o,
   output logic [PW-1:0]     idx_o
);

   logic [PW-1:0] slot;

   // Walk oldest to youngest; a later match overrides an earlier one, so the
   // entry closest to tail-1 wins.
   always_comb begin
      hit_o = 1'b0;
      idx_o = head_i;
      slot  = head_i;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head_i + i[PW-1:0];
         if (ld_valid_i && (CW'(i) < count_i) &&
             (entries_i[slot].addr[ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])) begin
            hit_o = 1'b1;
            idx_o = slot;
         end
      end
   end

endmodule

// File: rtl/store_commit_buffer.sv
// store_commit_buffer: circular buffer between retire and data memory.
// Accepts up to two retired stores per cycle (mem_req1 older), drains one
// per cycle in program order over a valid/ready port and forwards buffered
// store data to loads.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   mem_req1, mem_req2           : retired stores, req1 older than req2
//   stall_retire                 : fewer than two free slots guaranteed
//   dmem_req_valid/addr/wdata    : head entry offered to memory
//   dmem_ready                   : memory takes the head this cycle
//   ld_valid, ld_addr            : forwarding lookup
//   fwd_hit, fwd_data            : youngest matching buffered store
//   sb_empty, sb_count           : occupancy
//   overflow_err                 : sticky, a valid request was dropped
module store_commit_buffer
   import typedefs::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  memReqStruct                mem_req1,
   input  memReqStruct                mem_req2,
   output logic                       stall_retire,
   output logic                       dmem_req_valid,
   output logic [ADDR_W-1:0]          dmem_addr,
   output logic [DATA_W-1:0]          dmem_wdata,
   input  logic                       dmem_ready,
   input  logic                       ld_valid,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data,
   output logic                       sb_empty,
   output logic [$clog2(DEPTH):0]     sb_count,
   output logic                       overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   sbEntryStruct  mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic [1:0]    n_enq;
   logic [CW-1:0] free_slots;
   logic          accept;
   logic          drop;
   logic          pop;
   logic [PW-1:0] slot2;
   logic          fm_hit;
   logic [PW-1:0] fm_idx;

   always_comb begin
      n_enq      = {1'b0, mem_req1.valid} + {1'b0, mem_req2.valid};
      free_slots = CW'(DEPTH) - count_q;
      // Free space is judged on registered count only; a same-cycle pop
      // does not make room. Requests are taken all-or-nothing.
      accept     = (n_enq != 2'd0) && (CW'(n_enq) <= free_slots);
      drop       = (n_enq != 2'd0) && !accept;
      pop        = (count_q != '0) && dmem_ready;
      // req2 lands right after req1, or at tail when req1 is idle.
      slot2      = tail_q + PW'(mem_req1.valid);

      head_d  = head_q + PW'(pop);
      tail_d  = accept ? (tail_q + PW'(n_enq)) : tail_q;
      count_d = count_q + (accept ? CW'(n_enq) : '0) - CW'(pop);
      ovf_d   = ovf_q | drop;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Entry contents need no reset: occupancy is defined by head/count only.
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         if (mem_req1.valid) begin
            mem_q[tail_q] <= '{addr: mem_req1.addr, wr_data: mem_req1.wr_data};
         end
         if (mem_req2.valid) begin
            mem_q[slot2] <= '{addr: mem_req2.addr, wr_data: mem_req2.wr_data};
         end
      end
   end

   sb_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fwd_match (
      .head_i     (head_q),
      .count_i    (count_q),
      .entries_i  (mem_q),
      .ld_valid_i (ld_valid),
      .ld_addr_i  (ld_addr),
      .hit_o      (fm_hit),
      .idx_o      (fm_idx)
   );

   always_comb begin
      sb_empty       = (count_q == '0);
      sb_count       = count_q;
      stall_retire   = (count_q > CW'(DEPTH - 2));
      overflow_err   = ovf_q;
      dmem_req_valid = !sb_empty;
      // Gate the head so an empty buffer drives zeros rather than stale data.
      dmem_addr      = sb_empty ? '0 : mem_q[head_q].addr;
      dmem_wdata     = sb_empty ? '0 : mem_q[head_q].wr_data;
      fwd_hit        = fm_hit;
      fwd_data       = fm_hit ? mem_q[fm_idx].wr_data : '0;
   end

endmodule
